// File: rtl/instr_buffer_if.sv
// Instruction buffer payload types and the loader/fetch-side bus.
// The loader and fetch stage drive the I_* members; the buffer drives the O_* members.
package instr_buffer_pkg;
  localparam int unsigned INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instruction_t;

  typedef struct packed {
    logic         v;
    instruction_t instr;
  } instr_t;
endpackage

interface instr_buffer_if #(
  parameter int unsigned DEPTH = 64
);
  import instr_buffer_pkg::*;

  localparam int unsigned WIDTH_CNT = $clog2(DEPTH) + 1;

  logic                 I_We;
  logic                 I_Last;
  instruction_t         I_Instr;
  logic                 I_Start;
  logic                 I_Abort;
  logic                 I_Re;
  instr_t               O_Instr;
  logic                 O_Empty;
  logic                 O_Full;
  logic [WIDTH_CNT-1:0] O_Count;
  logic                 O_Term;

  modport master (
    output I_We, I_Last, I_Instr, I_Start, I_Abort, I_Re,
    input  O_Instr, O_Empty, O_Full, O_Count, O_Term
  );

  modport slave (
    input  I_We, I_Last, I_Instr, I_Start, I_Abort, I_Re,
    output O_Instr, O_Empty, O_Full, O_Count, O_Term
  );
endinterface

// File: rtl/instr_buffer.sv
// Instruction buffer: loader writes a program in order, fetch streams it out one entry
// per cycle with one cycle of read latency, and Term pulses when the last entry is delivered.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic           clock,
  input  logic           reset,
  instr_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, TERM} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
  logic               has_last_q, has_last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  instr_t             out_q, out_d;
  logic               we_c, re_c, full_c, is_last_c;

  instruction_t       mem [DEPTH];

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign is_last_c = has_last_q && (rd_ptr_q == last_ptr_q);

  // Next-state and datapath update; abort wins over every other request.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_ptr_d = last_ptr_q;
    has_last_d = has_last_q;
    count_d    = count_q;
    out_d      = out_q;
    out_d.v    = 1'b0;
    we_c       = 1'b0;
    re_c       = 1'b0;

    if (bus.I_Abort) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      has_last_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          we_c = bus.I_We;
          if (bus.I_We) state_d = LOAD;
        end
        LOAD: begin
          we_c = bus.I_We && !full_c;
          if (bus.I_Start && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          we_c = bus.I_We && !full_c;
          re_c = bus.I_Re && (count_q != '0);
          if (re_c && is_last_c) state_d = TERM;
        end
        TERM: begin
          state_d    = IDLE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          has_last_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase

      if (we_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (bus.I_Last) begin
          last_ptr_d = wr_ptr_q;
          has_last_d = 1'b1;
        end
      end

      if (re_c) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        out_d.v     = 1'b1;
        out_d.instr = mem[rd_ptr_q];
      end

      case ({we_c, re_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_d;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_ptr_q <= '0;
      has_last_q <= 1'b0;
      count_q    <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_ptr_q <= last_ptr_d;
      has_last_q <= has_last_d;
      count_q    <= count_d;
      out_q      <= out_d;
    end
  end

  // Storage array carries no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (reset && we_c) mem[wr_ptr_q] <= bus.I_Instr;
  end

  assign bus.O_Instr = out_q;
  assign bus.O_Count = count_q;
  assign bus.O_Full  = full_c;
  assign bus.O_Empty = (state_q != RUN) || (count_q == '0);
  assign bus.O_Term  = (state_q == TERM);

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: load/stream, full and wrap, underflow,
// concurrent read/write, abort and mid-stream reset.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  instr_buffer_if #(.DEPTH(DEPTH)) bus ();

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [31:0] d, input logic last);
    bus.I_We    = 1'b1;
    bus.I_Instr = d;
    bus.I_Last  = last;
    tick();
    bus.I_We    = 1'b0;
    bus.I_Last  = 1'b0;
  endtask

  task automatic start_run();
    bus.I_Start = 1'b1;
    tick();
    bus.I_Start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
    chk(tag, 64'(bus.O_Instr), 64'({v, d}));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.I_We    = 1'b0;
    bus.I_Last  = 1'b0;
    bus.I_Instr = '0;
    bus.I_Start = 1'b0;
    bus.I_Abort = 1'b0;
    bus.I_Re    = 1'b0;
    tick();
    tick();
    chk("rst_instr", 64'(bus.O_Instr), 64'd0);
    chk("rst_empty", 64'(bus.O_Empty), 64'd1);
    chk("rst_full",  64'(bus.O_Full),  64'd0);
    chk("rst_count", 64'(bus.O_Count), 64'd0);
    chk("rst_term",  64'(bus.O_Term),  64'd0);
    reset = 1'b1;
    tick();

    // 1: four entries, last on D, continuous read
    write_entry(32'hA000_000A, 1'b0);
    write_entry(32'hB000_000B, 1'b0);
    write_entry(32'hC000_000C, 1'b0);
    write_entry(32'hD000_000D, 1'b1);
    chk("t1_count", 64'(bus.O_Count), 64'd4);
    chk("t1_load_empty", 64'(bus.O_Empty), 64'd1);
    start_run();
    chk("t1_run_empty", 64'(bus.O_Empty), 64'd0);
    bus.I_Re = 1'b1;
    tick(); chk_out("t1_a", 1'b1, 32'hA000_000A); chk("t1_term_a", 64'(bus.O_Term), 64'd0);
    tick(); chk_out("t1_b", 1'b1, 32'hB000_000B); chk("t1_term_b", 64'(bus.O_Term), 64'd0);
    tick(); chk_out("t1_c", 1'b1, 32'hC000_000C); chk("t1_term_c", 64'(bus.O_Term), 64'd0);
    tick(); chk_out("t1_d", 1'b1, 32'hD000_000D); chk("t1_term_d", 64'(bus.O_Term), 64'd1);
    chk("t1_term_empty", 64'(bus.O_Empty), 64'd1);
    tick();
    bus.I_Re = 1'b0;
    chk_out("t1_idle_hold", 1'b0, 32'hD000_000D);
    chk("t1_idle_term", 64'(bus.O_Term), 64'd0);
    chk("t1_idle_count", 64'(bus.O_Count), 64'd0);
    chk("t1_idle_empty", 64'(bus.O_Empty), 64'd1);

    // 2: fill to DEPTH, overflow write dropped, stream across the pointer wrap
    for (int i = 0; i < 64; i++) write_entry(32'h1000_0000 + 32'(i), i == 63);
    chk("t2_full", 64'(bus.O_Full), 64'd1);
    chk("t2_count", 64'(bus.O_Count), 64'd64);
    write_entry(32'hDEAD_BEEF, 1'b0);
    chk("t2_ovf_count", 64'(bus.O_Count), 64'd64);
    chk("t2_ovf_full", 64'(bus.O_Full), 64'd1);
    start_run();
    bus.I_Re = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk_out("t2_data", 1'b1, 32'h1000_0000 + 32'(i));
      chk("t2_term", 64'(bus.O_Term), (i == 63) ? 64'd1 : 64'd0);
    end
    tick();
    bus.I_Re = 1'b0;
    chk("t2_end_count", 64'(bus.O_Count), 64'd0);
    chk("t2_end_full", 64'(bus.O_Full), 64'd0);

    // 3: underflow with no last flag
    write_entry(32'h3000_0003, 1'b0);
    start_run();
    bus.I_Re = 1'b1;
    tick();
    chk_out("t3_deliver", 1'b1, 32'h3000_0003);
    chk("t3_empty", 64'(bus.O_Empty), 64'd1);
    tick();
    chk_out("t3_under1", 1'b0, 32'h3000_0003);
    chk("t3_count1", 64'(bus.O_Count), 64'd0);
    chk("t3_term1", 64'(bus.O_Term), 64'd0);
    tick();
    chk_out("t3_under2", 1'b0, 32'h3000_0003);
    chk("t3_empty2", 64'(bus.O_Empty), 64'd1);
    chk("t3_term2", 64'(bus.O_Term), 64'd0);
    bus.I_Re    = 1'b0;
    bus.I_Abort = 1'b1;
    tick();
    bus.I_Abort = 1'b0;

    // 4: simultaneous write and read keeps count, FIFO order preserved
    for (int i = 0; i < 5; i++) write_entry(32'h4000_0000 + 32'(i), 1'b0);
    start_run();
    bus.I_We    = 1'b1;
    bus.I_Instr = 32'h4000_0005;
    bus.I_Last  = 1'b1;
    bus.I_Re    = 1'b1;
    tick();
    bus.I_We    = 1'b0;
    bus.I_Last  = 1'b0;
    chk_out("t4_first", 1'b1, 32'h4000_0000);
    chk("t4_count", 64'(bus.O_Count), 64'd5);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk_out("t4_data", 1'b1, 32'h4000_0000 + 32'(i));
      chk("t4_term", 64'(bus.O_Term), (i == 5) ? 64'd1 : 64'd0);
    end
    tick();
    bus.I_Re = 1'b0;

    // 5: abort beats concurrent write and read mid-stream
    for (int i = 0; i < 3; i++) write_entry(32'h5000_0000 + 32'(i), 1'b0);
    start_run();
    bus.I_Re = 1'b1;
    tick();
    chk_out("t5_first", 1'b1, 32'h5000_0000);
    bus.I_Abort = 1'b1;
    bus.I_We    = 1'b1;
    bus.I_Instr = 32'h5555_5555;
    tick();
    bus.I_Abort = 1'b0;
    bus.I_We    = 1'b0;
    bus.I_Re    = 1'b0;
    chk_out("t5_abort_out", 1'b0, 32'h5000_0000);
    chk("t5_abort_count", 64'(bus.O_Count), 64'd0);
    chk("t5_abort_empty", 64'(bus.O_Empty), 64'd1);
    chk("t5_abort_term", 64'(bus.O_Term), 64'd0);
    tick();
    chk("t5_idle_count", 64'(bus.O_Count), 64'd0);

    // 6: mid-stream reset, then reload and run
    for (int i = 0; i < 3; i++) write_entry(32'h6000_0000 + 32'(i), 1'b0);
    start_run();
    bus.I_Re = 1'b1;
    tick();
    chk_out("t6_first", 1'b1, 32'h6000_0000);
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    bus.I_Re = 1'b0;
    chk("t6_rst_instr", 64'(bus.O_Instr), 64'd0);
    chk("t6_rst_empty", 64'(bus.O_Empty), 64'd1);
    chk("t6_rst_full",  64'(bus.O_Full),  64'd0);
    chk("t6_rst_count", 64'(bus.O_Count), 64'd0);
    chk("t6_rst_term",  64'(bus.O_Term),  64'd0);
    write_entry(32'h7000_0000, 1'b0);
    write_entry(32'h7000_0001, 1'b1);
    chk("t6_count", 64'(bus.O_Count), 64'd2);
    start_run();
    bus.I_Re = 1'b1;
    tick();
    chk_out("t6_a", 1'b1, 32'h7000_0000);
    chk("t6_term_a", 64'(bus.O_Term), 64'd0);
    tick();
    chk_out("t6_b", 1'b1, 32'h7000_0001);
    chk("t6_term_b", 64'(bus.O_Term), 64'd1);
    tick();
    bus.I_Re = 1'b0;
    chk("t6_idle_term", 64'(bus.O_Term), 64'd0);
    chk("t6_idle_empty", 64'(bus.O_Empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
